elevator_scan_ctrl: RTL and testbench
=====================================

// Module: elevator_scan_ctrl
// PURPOSE
//  Parametrised elevator car controller: N floors, latched request queue, SCAN (elevator) scheduling,
//  timed floor-to-floor travel and timed door dwell. Successor to the fixed 4-floor controller.
//  Sits between the request panel (buttons, already debounced) and the floor indicator LEDs.
// PARAMETERS
//  NUM_FLOORS    4  number of floors, 2..16; floors are numbered 0..NUM_FLOORS-1
//  TRAVEL_CYCLES 4  clock cycles to move one floor, >=1
//  DOOR_CYCLES   3  clock cycles the door stays open per stop, >=1
//  FLOOR_W (localparam) = $clog2(NUM_FLOORS)
// PORTS
//  clk           in   1           clock; all state changes on rising edge
//  reset         in   1           synchronous, active-high
//  call_valid    in   1           request strobe, sampled each rising edge
//  call_floor    in   FLOOR_W     requested floor, valid when call_valid=1
//  current_floor out  FLOOR_W     floor the car is at (registered)
//  floor_led     out  NUM_FLOORS  one-hot of current_floor
//  pending       out  NUM_FLOORS  latched, unserved requests, bit i = floor i
//  moving_up     out  1           state==MOVE_UP
//  moving_down   out  1           state==MOVE_DOWN
//  door_open     out  1           state==DOOR_OPEN
//  idle          out  1           state==IDLE
// BEHAVIOUR
//  Reset: state IDLE, current_floor=0, floor_led=1, pending=0, travel/door counters=0, dir_up=1;
//   all outputs take these values on the edge reset is sampled, including mid-move or mid-door.
//  Request latch: call_valid & call_floor<NUM_FLOORS sets pending[call_floor] on that edge.
//   call_floor>=NUM_FLOORS is ignored. Repeat calls to an already-pending floor have no effect.
//  "above" = any pending bit > current_floor; "below" = any pending bit < current_floor.
//  IDLE: priority pending[current_floor] -> DOOR_OPEN (clear bit); else dir_up ? (above->UP, below->DOWN)
//   : (below->DOWN, above->UP); else stay. Decision uses the registered pending (1-cycle latch latency).
//  MOVE_UP/MOVE_DOWN: travel counter counts TRAVEL_CYCLES cycles; on the last, current_floor +/-1 and
//   on that same edge: pending[new floor] -> DOOR_OPEN (clear bit); else continue if requests ahead;
//   else reverse if requests behind; else IDLE. dir_up records direction of the last move.
//  DOOR_OPEN: door counter counts DOOR_CYCLES cycles; a call for current_floor while open restarts
//   the counter and does not set pending. On expiry: requests ahead (per dir_up) -> continue,
//   else behind -> reverse, else IDLE.
//  Simultaneous set/clear of the same pending bit on one edge: clear wins (stop is being served).
//  Car never passes floor 0 or NUM_FLOORS-1: motion only starts toward a pending bit.
//  floor_led is always exactly one-hot; moving_up/moving_down/door_open/idle are mutually exclusive,
//   exactly one high every cycle.
// TESTING (NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3 unless stated)
//  1. Assert reset 2 cycles -> current_floor=0, floor_led=4'b0001, pending=0, idle=1.
//  2. At floor 0, call 1 sampled at edge E0 -> pending=0010 after E0, moving_up after E1,
//     current_floor=1 and door_open after E5, pending=0, idle after E8.
//  3. At floor 0, calls 3 then 1 back-to-back -> car stops at 1 (door 3 cycles) then 3; never skips 1.
//  4. Moving up from 2 toward 3, call 0 and 1 -> serves 3, reverses, stops 1 then 0; dir_up=0 after.
//  5. Door open at 2, call 2 repeatedly every 2 cycles -> door_open held; closes 3 cycles after last call.
//  6. NUM_FLOORS=6: call_floor=7 -> pending unchanged; reset mid-move at floor 3 -> next cycle
//     current_floor=0, pending=0, idle=1.

Source files
------------

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator car controller: latched floor calls, timed travel between floors, timed door dwell.
// Latency: a call is visible on pending one edge after sampling; motion or door decisions follow on the next edge.
// Backpressure: none; calls are accepted every cycle, and a call for the open-door floor restarts the dwell.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3,
    localparam int FLOOR_W      = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] floor_led,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  idle
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    localparam int TRAV_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [TRAV_W-1:0]  TRAV_LAST      = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST      = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]   NUM_FLOORS_EXT = (FLOOR_W + 1)'(NUM_FLOORS);

    state_t                  state, state_nxt;
    logic [FLOOR_W-1:0]      floor_nxt;
    logic                    dir_up, dir_up_nxt;
    logic [TRAV_W-1:0]       travel_cnt, travel_nxt;
    logic [DOOR_W-1:0]       door_cnt, door_nxt;
    logic [NUM_FLOORS-1:0]   set_mask, clr_mask, pending_nxt;

    // Keep going the way we were heading while anything lies ahead, otherwise turn around, otherwise rest.
    function automatic state_t scan_next(input logic [NUM_FLOORS-1:0] req,
                                         input logic [FLOOR_W-1:0]    flr,
                                         input logic                  up);
        logic above;
        logic below;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (i > int'(flr))) above = 1'b1;
            if (req[i] && (i < int'(flr))) below = 1'b1;
        end
        if (up ? above : below) return up ? ST_MOVE_UP : ST_MOVE_DOWN;
        if (up ? below : above) return up ? ST_MOVE_DOWN : ST_MOVE_UP;
        return ST_IDLE;
    endfunction

    always_comb begin
        set_mask = '0;
        if (call_valid && ({1'b0, call_floor} < NUM_FLOORS_EXT) &&
            !(state == ST_DOOR_OPEN && call_floor == current_floor)) begin
            set_mask[call_floor] = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        floor_nxt  = current_floor;
        dir_up_nxt = dir_up;
        travel_nxt = travel_cnt;
        door_nxt   = door_cnt;
        clr_mask   = '0;
        case (state)
            ST_IDLE: begin
                if (pending[current_floor]) begin
                    state_nxt               = ST_DOOR_OPEN;
                    clr_mask[current_floor] = 1'b1;
                    door_nxt                = '0;
                end else begin
                    state_nxt  = scan_next(pending, current_floor, dir_up);
                    travel_nxt = '0;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (travel_cnt == TRAV_LAST) begin
                    floor_nxt  = (state == ST_MOVE_UP) ? current_floor + FLOOR_W'(1)
                                                       : current_floor - FLOOR_W'(1);
                    travel_nxt = '0;
                    if (pending[floor_nxt]) begin
                        state_nxt           = ST_DOOR_OPEN;
                        clr_mask[floor_nxt] = 1'b1;
                        door_nxt            = '0;
                    end else begin
                        state_nxt = scan_next(pending, floor_nxt, dir_up);
                    end
                end else begin
                    travel_nxt = travel_cnt + TRAV_W'(1);
                end
            end
            ST_DOOR_OPEN: begin
                // A passenger pressing the open floor's button holds the door rather than queueing a stop.
                if (call_valid && call_floor == current_floor) begin
                    door_nxt = '0;
                end else if (door_cnt == DOOR_LAST) begin
                    state_nxt  = scan_next(pending, current_floor, dir_up);
                    door_nxt   = '0;
                    travel_nxt = '0;
                end else begin
                    door_nxt = door_cnt + DOOR_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_MOVE_UP) begin
            dir_up_nxt = 1'b1;
        end else if (state_nxt == ST_MOVE_DOWN) begin
            dir_up_nxt = 1'b0;
        end
    end

    // Clear after set so a stop being served on this edge is not re-latched by a coincident call.
    assign pending_nxt = (pending | set_mask) & ~clr_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            travel_cnt    <= '0;
            door_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            current_floor <= floor_nxt;
            pending       <= pending_nxt;
            dir_up        <= dir_up_nxt;
            travel_cnt    <= travel_nxt;
            door_cnt      <= door_nxt;
        end
    end

    assign floor_led   = NUM_FLOORS'(1) << current_floor;
    assign moving_up   = (state == ST_MOVE_UP);
    assign moving_down = (state == ST_MOVE_DOWN);
    assign door_open   = (state == ST_DOOR_OPEN);
    assign idle        = (state == ST_IDLE);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl (6 floors): directed scenarios plus random calls/resets,
// every cycle scored against a countdown-based behavioural model through an expectation queue.
module tb_elevator_scan_ctrl;
    localparam int NF = 6;
    localparam int TC = 4;
    localparam int DC = 3;
    localparam int FW = 3;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          call_valid = 1'b0;
    logic [FW-1:0] call_floor = '0;
    logic [FW-1:0] current_floor;
    logic [NF-1:0] floor_led;
    logic [NF-1:0] pending;
    logic          moving_up, moving_down, door_open, idle;

    elevator_scan_ctrl #(
        .NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
        .current_floor(current_floor), .floor_led(floor_led), .pending(pending),
        .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    // Reference model: integer floor, direction +1/-1, activity with cycles remaining.
    bit model_valid = 1'b0;
    bit mpend[NF];
    int mfloor, mdir, mmode, mrem;

    function automatic bit has_req(input int f, input int d);
        for (int p = 0; p < NF; p++)
            if (mpend[p] && (p - f) * d > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic depart();
        if (has_req(mfloor, mdir)) begin
            mmode = M_MOVE; mrem = TC;
        end else if (has_req(mfloor, -mdir)) begin
            mdir = -mdir; mmode = M_MOVE; mrem = TC;
        end else begin
            mmode = M_IDLE;
        end
    endtask

    function automatic logic [18:0] model_out();
        logic [NF-1:0] pv;
        logic [NF-1:0] led;
        for (int p = 0; p < NF; p++) pv[p] = mpend[p];
        led = '0;
        led[mfloor] = 1'b1;
        return {3'(mfloor), led, pv, (mmode == M_MOVE && mdir > 0), (mmode == M_MOVE && mdir < 0),
                (mmode == M_DOOR), (mmode == M_IDLE)};
    endfunction

    always @(posedge clk) begin : model
        int of, om, clr_f, cf;
        bit cv;
        cv = call_valid;
        cf = int'(call_floor);
        if (reset) begin
            for (int p = 0; p < NF; p++) mpend[p] = 1'b0;
            mfloor = 0; mdir = 1; mmode = M_IDLE; mrem = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            of = mfloor; om = mmode; clr_f = -1;
            case (mmode)
                M_IDLE: begin
                    if (mpend[mfloor]) begin
                        mmode = M_DOOR; mrem = DC; clr_f = mfloor;
                    end else depart();
                end
                M_MOVE: begin
                    mrem = mrem - 1;
                    if (mrem == 0) begin
                        mfloor = mfloor + mdir;
                        if (mpend[mfloor]) begin
                            mmode = M_DOOR; mrem = DC; clr_f = mfloor;
                        end else depart();
                    end
                end
                default: begin
                    if (cv && cf == mfloor) mrem = DC;
                    else begin
                        mrem = mrem - 1;
                        if (mrem == 0) depart();
                    end
                end
            endcase
            if (cv && cf < NF && !(om == M_DOOR && cf == of)) mpend[cf] = 1'b1;
            if (clr_f >= 0) mpend[clr_f] = 1'b0;
        end
        if (model_valid) exp_q.push_back(model_out());
    end

    always @(negedge clk) begin : monitor
        logic [18:0] exp_v, act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {current_floor, floor_led, pending, moving_up, moving_down, door_open, idle};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cycle t=%0t actual floor=%0d led=%b pend=%b up/dn/door/idle=%b required floor=%0d led=%b pend=%b up/dn/door/idle=%b",
                         $time, act_v[18:16], act_v[15:10], act_v[9:4], act_v[3:0],
                         exp_v[18:16], exp_v[15:10], exp_v[9:4], exp_v[3:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; call_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic call(input int f);
        call_valid = 1'b1; call_floor = FW'(f);
        tick();
        call_valid = 1'b0;
    endtask

    int  stops[$];
    bit  prev;
    int  ph;
    int  exp_stops[3];

    initial begin
        // Test 1: two reset cycles
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_floor", int'(current_floor), 0);
        chk("reset_led", int'(floor_led), 1);
        chk("reset_pending", int'(pending), 0);
        chk("reset_idle", int'(idle), 1);

        // Test 2: single call to floor 1, edge-by-edge timing
        call(1);
        chk("t2_pending_E0", int'(pending), 2);
        tick(); chk("t2_up_E1", int'(moving_up), 1);
        repeat (3) tick();
        chk("t2_floor_E4", int'(current_floor), 0);
        tick();
        chk("t2_door_E5", int'(door_open), 1);
        chk("t2_floor_E5", int'(current_floor), 1);
        chk("t2_pending_E5", int'(pending), 0);
        repeat (2) tick(); chk("t2_door_E7", int'(door_open), 1);
        tick(); chk("t2_idle_E8", int'(idle), 1);

        // Test 3: calls 3 then 1 back-to-back from floor 0
        reset_dut();
        call(3); call(1);
        stops.delete(); prev = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (door_open && !prev) stops.push_back(int'(current_floor));
            prev = door_open;
        end
        chk("t3_nstops", stops.size(), 2);
        chk("t3_stop0", (stops.size() > 0) ? stops[0] : -1, 1);
        chk("t3_stop1", (stops.size() > 1) ? stops[1] : -1, 3);

        // Test 4: heading to 3, calls for 0 and 1 made while passing floor 2
        reset_dut();
        call(3);
        stops.delete(); prev = 1'b0; ph = 0;
        for (int k = 0; k < 120; k++) begin
            call_valid = 1'b0;
            if (ph == 0 && current_floor == 2 && moving_up) begin
                call_valid = 1'b1; call_floor = 0; ph = 1;
            end else if (ph == 1) begin
                call_valid = 1'b1; call_floor = 1; ph = 2;
            end
            tick();
            if (door_open && !prev) stops.push_back(int'(current_floor));
            prev = door_open;
        end
        call_valid = 1'b0;
        exp_stops = '{3, 1, 0};
        chk("t4_nstops", stops.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t4_stop%0d", i), (stops.size() > i) ? stops[i] : -1, exp_stops[i]);

        // Test 5: door held open at floor 2 by repeated calls
        reset_dut();
        call(2);
        for (int k = 0; k < 40 && !door_open; k++) tick();
        chk("t5_door_reached", int'(door_open), 1);
        for (int r = 0; r < 4; r++) begin
            call(2);
            chk("t5_door_held", int'(door_open), 1);
            tick();
            chk("t5_door_held2", int'(door_open), 1);
        end
        chk("t5_no_pending", int'(pending), 0);
        tick(); chk("t5_open_last", int'(door_open), 1);
        tick(); chk("t5_closed", int'(idle), 1);

        // Test 6: out-of-range calls ignored; reset during a move
        call(7); call(6);
        chk("t6_ignored", int'(pending), 0);
        chk("t6_idle", int'(idle), 1);
        call(5);
        for (int k = 0; k < 40 && !(current_floor == 3 && moving_up); k++) tick();
        chk("t6_at3", int'(current_floor), 3);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_rst_floor", int'(current_floor), 0);
        chk("t6_rst_pending", int'(pending), 0);
        chk("t6_rst_idle", int'(idle), 1);

        // Random traffic, biased towards the car's own floor to exercise door holds
        for (int k = 0; k < 4000; k++) begin
            reset      = ($urandom_range(0, 999) < 3);
            call_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) call_floor = FW'(mfloor);
            else call_floor = FW'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0; call_valid = 1'b0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
